pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 139 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage with optional two-entry skid buffer, exception-triggered drain
// mode and a saturating counter of idle output cycles.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 9,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_exc_any,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic [EXC_W-1:0]    head_exc_q, head_exc_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [EXC_W-1:0]    skid_exc_q, skid_exc_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    bubble_q, bubble_d;
    logic                in_hs;
    logic                out_hs;

    // The head register drives the outputs directly; in DRAIN nothing is presented.
    assign out_valid   = (state_q == RUN) && (occ_q != 2'd0);
    assign out_data    = head_data_q;
    assign out_exc     = head_exc_q;
    assign out_exc_any = out_valid && (|head_exc_q);
    assign occupancy   = occ_q;
    assign bubble_cnt  = bubble_q;

    // Skid mode uses the registered ready; single-entry mode lets a draining head make room.
    assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Next-state computation: flush dominates, DRAIN swallows input, RUN moves the FIFO.
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_exc_d  = head_exc_q;
        skid_data_d = skid_data_q;
        skid_exc_d  = skid_exc_q;
        bubble_d    = bubble_q;

        if ((state_q == RUN) && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = RUN;
            occ_d   = 2'd0;
        end else if (state_q == DRAIN) begin
            occ_d = 2'd0;
        end else if (out_hs && (|head_exc_q)) begin
            state_d = DRAIN;
            occ_d   = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (in_hs) begin
                        head_data_d = in_data;
                        head_exc_d  = in_exc;
                        occ_d       = 2'd1;
                    end
                end
                2'd1: begin
                    if (out_hs && in_hs) begin
                        head_data_d = in_data;
                        head_exc_d  = in_exc;
                    end else if (out_hs) begin
                        occ_d = 2'd0;
                    end else if (in_hs) begin
                        skid_data_d = in_data;
                        skid_exc_d  = in_exc;
                        occ_d       = 2'd2;
                    end
                end
                default: begin
                    if (out_hs) begin
                        head_data_d = skid_data_q;
                        head_exc_d  = skid_exc_q;
                        if (in_hs) begin
                            skid_data_d = in_data;
                            skid_exc_d  = in_exc;
                        end else begin
                            occ_d = 2'd1;
                        end
                    end
                end
            endcase
        end

        in_ready_d = (state_d == DRAIN) || (occ_d != 2'd2);
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            occ_q       <= 2'd0;
            head_data_q <= '0;
            head_exc_q  <= '0;
            skid_data_q <= '0;
            skid_exc_q  <= '0;
            in_ready_q  <= 1'b1;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_exc_q  <= head_exc_d;
            skid_data_q <= skid_data_d;
            skid_exc_q  <= skid_exc_d;
            in_ready_q  <= in_ready_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and compares both
// against a queue-style reference model of the stage.
module tb_pipe_skid_stage;

    localparam int DW = 16;
    localparam int EW = 9;
    localparam int CW = 4;
    localparam int BUB_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [EW-1:0] in_exc = '0;
    logic          out_ready = 1'b0;

    logic          a_in_ready, a_out_valid, a_exc_any;
    logic [DW-1:0] a_out_data;
    logic [EW-1:0] a_out_exc;
    logic [1:0]    a_occ;
    logic [CW-1:0] a_bub;

    logic          b_in_ready, b_out_valid, b_exc_any;
    logic [DW-1:0] b_out_data;
    logic [EW-1:0] b_out_exc;
    logic [1:0]    b_occ;
    logic [CW-1:0] b_bub;

    int checks = 0;
    int failures = 0;

    // Reference model: per instance, an ordered list of at most two entries.
    logic [DW-1:0] m_data [2][2];
    logic [EW-1:0] m_exc  [2][2];
    int            m_cnt  [2];
    bit            m_drain[2];
    int            m_bub  [2];
    logic [DW-1:0] next_data = 16'd1;

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(1), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_exc(in_exc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_exc(a_out_exc), .out_exc_any(a_exc_any), .occupancy(a_occ),
        .bubble_cnt(a_bub)
    );

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(0), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_exc(in_exc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_exc(b_out_exc), .out_exc_any(b_exc_any), .occupancy(b_occ),
        .bubble_cnt(b_bub)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelInReady(input int i);
        if (m_drain[i]) return 1'b1;
        if (i == 0) return (m_cnt[i] < 2);
        return (m_cnt[i] == 0) || out_ready;
    endfunction

    task automatic checkDut(input int i);
        logic          ir, ov, ea;
        logic [DW-1:0] od;
        logic [EW-1:0] oe;
        logic [1:0]    oc;
        logic [CW-1:0] bc;
        string         p;
        bit            exp_valid;
        if (i == 0) begin
            ir = a_in_ready; ov = a_out_valid; ea = a_exc_any; od = a_out_data;
            oe = a_out_exc; oc = a_occ; bc = a_bub; p = "skid1";
        end else begin
            ir = b_in_ready; ov = b_out_valid; ea = b_exc_any; od = b_out_data;
            oe = b_out_exc; oc = b_occ; bc = b_bub; p = "skid0";
        end
        exp_valid = !m_drain[i] && (m_cnt[i] > 0);
        checkOutput({p, ".in_ready"}, 64'(ir), 64'(modelInReady(i)));
        checkOutput({p, ".out_valid"}, 64'(ov), 64'(exp_valid));
        checkOutput({p, ".occupancy"}, 64'(oc), 64'(m_drain[i] ? 0 : m_cnt[i]));
        checkOutput({p, ".bubble_cnt"}, 64'(bc), 64'(m_bub[i]));
        if (exp_valid) begin
            checkOutput({p, ".out_data"}, 64'(od), 64'(m_data[i][0]));
            checkOutput({p, ".out_exc"}, 64'(oe), 64'(m_exc[i][0]));
            checkOutput({p, ".out_exc_any"}, 64'(ea), 64'(m_exc[i][0] != 0));
        end else begin
            checkOutput({p, ".out_exc_any"}, 64'(ea), 64'd0);
        end
    endtask

    task automatic modelStep(input int i);
        bit in_hs, out_hs;
        logic [EW-1:0] head_exc;
        if (rst) begin
            m_cnt[i] = 0; m_drain[i] = 0; m_bub[i] = 0;
            return;
        end
        if (!m_drain[i] && m_cnt[i] == 0 && m_bub[i] < BUB_MAX) m_bub[i]++;
        in_hs  = in_valid && modelInReady(i);
        out_hs = !m_drain[i] && (m_cnt[i] > 0) && out_ready;
        if (flush) begin
            m_cnt[i] = 0; m_drain[i] = 0;
            return;
        end
        if (m_drain[i]) return;
        if (out_hs) begin
            head_exc = m_exc[i][0];
            m_data[i][0] = m_data[i][1];
            m_exc[i][0]  = m_exc[i][1];
            m_cnt[i]--;
            if (head_exc != 0) begin
                m_drain[i] = 1; m_cnt[i] = 0;
                return;
            end
        end
        if (in_hs) begin
            m_data[i][m_cnt[i]] = in_data;
            m_exc[i][m_cnt[i]]  = in_exc;
            m_cnt[i]++;
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [EW-1:0] ex, input logic ordy);
        bit accepted;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_exc = ex; out_ready = ordy;
        in_data = next_data;
        #1;
        checkDut(0);
        checkDut(1);
        accepted = v && modelInReady(0);
        modelStep(0);
        modelStep(1);
        if (accepted) next_data++;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_drain[i] = 0; m_bub[i] = 0;
        end
        @(posedge clk);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("reset.skid1.out_data", 64'(a_out_data), 64'd0);
        checkOutput("reset.skid1.out_exc", 64'(a_out_exc), 64'd0);
        checkOutput("reset.skid0.out_data", 64'(b_out_data), 64'd0);
        applyStimulus(1, 0, 0, 0, 1);

        // Streaming
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, 0, 1);
        // Backpressure then release
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 1);
        // Exception at head with a younger entry behind it
        applyStimulus(0, 0, 1, 9'h008, 0);
        applyStimulus(0, 0, 1, 9'h000, 0);
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        // Flush colliding with an input offer while full
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        // Long idle to saturate the bubble counter
        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 1);
        // DRAIN cycles must not count, flush must not clear
        applyStimulus(0, 0, 1, 9'h100, 1);
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 1);
        // Toggling downstream ready with a continuous stream
        for (int k = 0; k < 12; k++) applyStimulus(0, 0, 1, 0, (k % 2) == 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic r, f, v, o;
            logic [EW-1:0] ex;
            r  = ($urandom_range(0, 249) == 0);
            f  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            o  = ($urandom_range(0, 2) != 0);
            ex = ($urandom_range(0, 9) == 0) ? EW'(1) << $urandom_range(0, EW-1) : '0;
            applyStimulus(r, f, v, ex, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
